// File: rtl/hydra_wrr_sched.sv
// Per-output-port read scheduler: picks one of four priority queues per downstream
// request (weighted round robin or strict priority) and holds the port until end of packet.
module hydra_wrr_sched #(
    parameter int W0      = 8,
    parameter int W1      = 4,
    parameter int W2      = 2,
    parameter int W3      = 1,
    parameter int CW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrr_en,
    input  logic [3:0] queue_nonempty,
    input  logic       ready,
    input  logic       pkt_done,
    output logic       grant_vld,
    output logic [1:0] grant_pri,
    output logic       busy,
    output logic       timeout_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ARB, SERVE} state_t;

    state_t          state_q, state_d;
    logic            pend_q, pend_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            grant_vld_q, grant_vld_d;
    logic [1:0]      grant_pri_q, grant_pri_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   credit_q [4];
    logic [CW-1:0]   credit_d [4];

    logic            any_ne;
    logic [1:0]      sel_strict, sel_wrr, idx;
    logic            found, found_rl, reload;
    logic [CW-1:0]   sel_base, sel_rem;

    // A zero weight would starve its queue forever, so it is promoted to 1.
    function automatic logic [CW-1:0] wt(input logic [1:0] p);
        int w;
        case (p)
            2'd0:    w = W0;
            2'd1:    w = W1;
            2'd2:    w = W2;
            default: w = W3;
        endcase
        return (w == 0) ? CW'(1) : CW'(w);
    endfunction

    assign any_ne = |queue_nonempty;

    always_comb begin
        sel_strict = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (queue_nonempty[i]) sel_strict = 2'(i);
        end
    end

    // First pass honours credits; the second pass models the same-cycle reload.
    always_comb begin
        found    = 1'b0;
        found_rl = 1'b0;
        sel_wrr  = ptr_q;
        idx      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && queue_nonempty[idx] && credit_q[idx] != '0) begin
                found   = 1'b1;
                sel_wrr = idx;
            end
        end
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && !found_rl && queue_nonempty[idx]) begin
                found_rl = 1'b1;
                sel_wrr  = idx;
            end
        end
        reload   = !found;
        sel_base = reload ? wt(sel_wrr) : credit_q[sel_wrr];
        sel_rem  = sel_base - CW'(1);
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ptr_d       = ptr_q;
        wd_d        = wd_q;
        grant_vld_d = 1'b0;
        grant_pri_d = grant_pri_q;
        timeout_d   = 1'b0;
        credit_d    = credit_q;
        case (state_q)
            IDLE: begin
                if (pend_q && any_ne) state_d = ARB;
            end
            ARB: begin
                pend_d = 1'b0;
                if (any_ne) begin
                    grant_vld_d = 1'b1;
                    wd_d        = '0;
                    state_d     = SERVE;
                    if (wrr_en) begin
                        grant_pri_d = sel_wrr;
                        for (int p = 0; p < 4; p++) begin
                            if (reload) credit_d[p] = wt(2'(p));
                        end
                        credit_d[sel_wrr] = sel_rem;
                        ptr_d = (sel_rem != '0) ? sel_wrr : sel_wrr + 2'd1;
                    end else begin
                        grant_pri_d = sel_strict;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE: begin
                if (pkt_done) begin
                    state_d = IDLE;
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (ready) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            ptr_q       <= 2'd0;
            wd_q        <= '0;
            grant_vld_q <= 1'b0;
            grant_pri_q <= 2'd0;
            timeout_q   <= 1'b0;
            for (int p = 0; p < 4; p++) credit_q[p] <= wt(2'(p));
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            wd_q        <= wd_d;
            grant_vld_q <= grant_vld_d;
            grant_pri_q <= grant_pri_d;
            timeout_q   <= timeout_d;
            credit_q    <= credit_d;
        end
    end

    assign grant_vld   = grant_vld_q;
    assign grant_pri   = grant_pri_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != IDLE);

endmodule
